// File: rtl/stream_cipher_pkg.sv
// Shared types and widths for the stream-cipher datapath blocks.
package stream_cipher_pkg;

    localparam int unsigned ByteWidth  = 8;
    localparam int unsigned CountWidth = 32;
    localparam int unsigned TimerWidth = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_KS = 2'd2,
        OUT     = 2'd3
    } keystream_xor_state_t;

endpackage

// File: rtl/keystream_timeout_counter.sv
// Wait timer for keystream bytes: synchronous clear, count enable,
// saturates at LIMIT, and flags the single cycle in which LIMIT is reached.
module keystream_timeout_counter
    import stream_cipher_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic nrst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired_c
);

    localparam logic [TimerWidth-1:0] LimitVal = TimerWidth'(LIMIT);
    localparam logic [TimerWidth-1:0] LastVal  = TimerWidth'(LIMIT - 1);

    logic [TimerWidth-1:0] r_count;
    logic                  w_at_limit;

    assign w_at_limit  = (r_count == LimitVal);

    // Expiry is an event: the counted cycle that takes the timer onto LIMIT.
    assign o_expired_c = i_enable && !i_clear && (r_count == LastVal);

    // Counter with clear priority and saturation at LIMIT.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_at_limit) begin
            r_count <= r_count + TimerWidth'(1);
        end
    end

endmodule

// File: rtl/keystream_xor.sv
// XORs each accepted byte with one keystream byte fetched from the hash
// generator, with a sticky timeout flag and a delivered-byte counter.
// Optional macro KEYSTREAM_XOR_PREFETCH_EN keeps one keystream byte buffered
// ahead of demand so an accepted byte can be emitted on the next cycle.
module keystream_xor
    import stream_cipher_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [ByteWidth-1:0]  data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [ByteWidth-1:0]  data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready,
    output logic                  request_hash_byte_pulse,
    input  logic [ByteWidth-1:0]  hash_byte_in,
    input  logic                  hash_byte_pulse_in,
    output logic [CountWidth-1:0] byte_count_out,
    output logic                  timeout_err_out,
    input  logic                  clear_err
);

    keystream_xor_state_t r_state;
    keystream_xor_state_t w_next_state;

    logic [ByteWidth-1:0]  r_data;
    logic [ByteWidth-1:0]  r_data_out;
    logic                  r_out_valid;
    logic                  r_in_ready;
    logic                  r_req;
    logic [CountWidth-1:0] r_byte_count;
    logic                  r_timeout_err;

    logic                  w_accept;
    logic                  w_latch_data;
    logic                  w_load_out;
    logic [ByteWidth-1:0]  w_out_byte;
    logic                  w_count_inc;
    logic                  w_wait_hit;
    logic                  w_req_next;
    logic                  w_timer_clr;
    logic                  w_timer_en;
    logic                  w_expired_c;

`ifdef KEYSTREAM_XOR_PREFETCH_EN
    logic [ByteWidth-1:0]  r_ks_buf;
    logic                  r_ks_valid;
    logic                  r_pending;
    logic                  w_pulse_ok;
    logic                  w_buf_load;
    logic                  w_buf_consume;
    logic                  w_issue;

    // Only a pulse answering our own outstanding request is captured.
    assign w_pulse_ok = hash_byte_pulse_in && r_pending;
    assign w_issue    = !r_ks_valid && !r_pending;
    assign w_req_next = w_issue;
`else
    assign w_req_next = (w_next_state == REQ);
`endif

    assign w_accept    = data_in_valid && r_in_ready;
    assign w_timer_clr = (r_state != WAIT_KS);
    assign w_timer_en  = (r_state == WAIT_KS) && !w_wait_hit;

    keystream_timeout_counter #(
        .LIMIT       (WAIT_TIMEOUT)
    ) u_timeout (
        .clk         (clk),
        .nrst        (nrst),
        .i_clear     (w_timer_clr),
        .i_enable    (w_timer_en),
        .o_expired_c (w_expired_c)
    );

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        w_next_state  = r_state;
        w_latch_data  = 1'b0;
        w_load_out    = 1'b0;
        w_out_byte    = '0;
        w_count_inc   = 1'b0;
        w_wait_hit    = 1'b0;
`ifdef KEYSTREAM_XOR_PREFETCH_EN
        w_buf_load    = 1'b0;
        w_buf_consume = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (r_ks_valid) begin
                        w_next_state  = OUT;
                        w_load_out    = 1'b1;
                        w_out_byte    = data_in ^ r_ks_buf;
                        w_buf_consume = 1'b1;
                    end else if (w_pulse_ok) begin
                        // Keystream lands on the accept cycle: bypass the buffer.
                        w_next_state  = OUT;
                        w_load_out    = 1'b1;
                        w_out_byte    = data_in ^ hash_byte_in;
                    end else begin
                        w_next_state  = WAIT_KS;
                        w_latch_data  = 1'b1;
                    end
                end else if (w_pulse_ok) begin
                    w_buf_load = 1'b1;
                end
            end
            REQ: begin
                w_next_state = IDLE;
                w_buf_load   = w_pulse_ok;
            end
            WAIT_KS: begin
                if (w_pulse_ok) begin
                    w_next_state = OUT;
                    w_load_out   = 1'b1;
                    w_out_byte   = r_data ^ hash_byte_in;
                    w_wait_hit   = 1'b1;
                end
            end
            OUT: begin
                if (data_out_ready) begin
                    w_next_state = IDLE;
                    w_count_inc  = 1'b1;
                end
                w_buf_load = w_pulse_ok;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
`else
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = REQ;
                    w_latch_data = 1'b1;
                end
            end
            REQ: begin
                w_next_state = WAIT_KS;
            end
            WAIT_KS: begin
                if (hash_byte_pulse_in) begin
                    w_next_state = OUT;
                    w_load_out   = 1'b1;
                    w_out_byte   = r_data ^ hash_byte_in;
                    w_wait_hit   = 1'b1;
                end
            end
            OUT: begin
                if (data_out_ready) begin
                    w_next_state = IDLE;
                    w_count_inc  = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
`endif
    end

    // Registered outputs, latched input byte, counter and sticky error flag.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_data        <= '0;
            r_data_out    <= '0;
            r_out_valid   <= 1'b0;
            r_in_ready    <= 1'b1;
            r_req         <= 1'b0;
            r_byte_count  <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_in_ready  <= (w_next_state == IDLE);
            r_out_valid <= (w_next_state == OUT);
            r_req       <= w_req_next;
            if (w_latch_data) begin
                r_data <= data_in;
            end
            if (w_load_out) begin
                r_data_out <= w_out_byte;
            end
            if (w_count_inc) begin
                r_byte_count <= r_byte_count + CountWidth'(1);
            end
            // A timeout landing with clear_err keeps the flag set.
            if (w_expired_c) begin
                r_timeout_err <= 1'b1;
            end else if (clear_err) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

`ifdef KEYSTREAM_XOR_PREFETCH_EN
    // One-entry keystream buffer and outstanding-request tracking.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_ks_buf   <= '0;
            r_ks_valid <= 1'b0;
            r_pending  <= 1'b0;
        end else begin
            if (w_buf_load) begin
                r_ks_buf   <= hash_byte_in;
                r_ks_valid <= 1'b1;
            end else if (w_buf_consume) begin
                r_ks_valid <= 1'b0;
            end
            if (w_issue) begin
                r_pending <= 1'b1;
            end else if (w_pulse_ok) begin
                r_pending <= 1'b0;
            end
        end
    end
`endif

    assign data_in_ready           = r_in_ready;
    assign data_out                = r_data_out;
    assign data_out_valid          = r_out_valid;
    assign request_hash_byte_pulse = r_req;
    assign byte_count_out          = r_byte_count;
    assign timeout_err_out         = r_timeout_err;

endmodule

// File: tb/tb_keystream_xor.sv
// Self-checking bench for keystream_xor (default build, no prefetch).
module tb_keystream_xor;

    localparam int unsigned Timeout = 4;

    logic        clk = 1'b0;
    logic        nrst;
    logic [7:0]  data_in;
    logic        data_in_valid;
    logic        data_in_ready;
    logic [7:0]  data_out;
    logic        data_out_valid;
    logic        data_out_ready;
    logic        request_hash_byte_pulse;
    logic [7:0]  hash_byte_in;
    logic        hash_byte_pulse_in;
    logic [31:0] byte_count_out;
    logic        timeout_err_out;
    logic        clear_err;

    int          n_checks = 0;
    int          n_err    = 0;
    int          req_cnt  = 0;
    logic [31:0] exp_count;

    typedef struct {
        logic [7:0] d;
        logic [7:0] k;
        int         ks_dly;
        int         sink_dly;
        bit         junk;
        logic [7:0] exp_out;
    } vec_t;

    vec_t vecs[6];

    keystream_xor #(
        .WAIT_TIMEOUT            (Timeout)
    ) dut (
        .clk                     (clk),
        .nrst                    (nrst),
        .data_in                 (data_in),
        .data_in_valid           (data_in_valid),
        .data_in_ready           (data_in_ready),
        .data_out                (data_out),
        .data_out_valid          (data_out_valid),
        .data_out_ready          (data_out_ready),
        .request_hash_byte_pulse (request_hash_byte_pulse),
        .hash_byte_in            (hash_byte_in),
        .hash_byte_pulse_in      (hash_byte_pulse_in),
        .byte_count_out          (byte_count_out),
        .timeout_err_out         (timeout_err_out),
        .clear_err               (clear_err)
    );

    always #5 clk = ~clk;

    // Count request pulses, one per high cycle.
    always @(posedge clk) begin
        if (request_hash_byte_pulse === 1'b1) begin
            req_cnt <= req_cnt + 1;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One complete byte transfer starting from IDLE at a negedge.
    task automatic xfer(input string tag, input logic [7:0] d, input logic [7:0] k,
                        input int ks_dly, input int sink_dly, input bit junk,
                        input logic [7:0] exp_out);
        int req0;
        req0 = req_cnt;
        chk({tag, ".in_ready"}, 32'(data_in_ready), 32'd1);
        data_in       = d;
        data_in_valid = 1'b1;
        @(negedge clk);
        data_in_valid = 1'b0;
        data_in       = 8'($urandom);
        chk({tag, ".req"}, 32'(request_hash_byte_pulse), 32'd1);
        chk({tag, ".busy"}, 32'(data_in_ready), 32'd0);
        if (junk) begin
            hash_byte_in       = ~k;
            hash_byte_pulse_in = 1'b1;
        end
        @(negedge clk);
        hash_byte_pulse_in = 1'b0;
        repeat (ks_dly) @(negedge clk);
        chk({tag, ".wait_valid"}, 32'(data_out_valid), 32'd0);
        hash_byte_in       = k;
        hash_byte_pulse_in = 1'b1;
        @(negedge clk);
        hash_byte_pulse_in = 1'b0;
        hash_byte_in       = 8'($urandom);
        chk({tag, ".valid"}, 32'(data_out_valid), 32'd1);
        chk({tag, ".data"}, 32'(data_out), 32'(exp_out));
        for (int i = 0; i < sink_dly; i++) begin
            if (junk) begin
                hash_byte_in       = ~k;
                hash_byte_pulse_in = 1'b1;
            end
            @(negedge clk);
            hash_byte_pulse_in = 1'b0;
            chk({tag, ".hold_valid"}, 32'(data_out_valid), 32'd1);
            chk({tag, ".hold_data"}, 32'(data_out), 32'(exp_out));
            chk({tag, ".hold_busy"}, 32'(data_in_ready), 32'd0);
        end
        data_out_ready = 1'b1;
        @(negedge clk);
        data_out_ready = 1'b0;
        exp_count      = exp_count + 32'd1;
        chk({tag, ".count"}, byte_count_out, exp_count);
        chk({tag, ".done_valid"}, 32'(data_out_valid), 32'd0);
        chk({tag, ".idle_ready"}, 32'(data_in_ready), 32'd1);
        chk({tag, ".one_req"}, 32'(req_cnt - req0), 32'd1);
    endtask

    initial begin
        int         req0;
        logic [7:0] rd;
        logic [7:0] rk;

        nrst               = 1'b0;
        data_in            = '0;
        data_in_valid      = 1'b0;
        data_out_ready     = 1'b0;
        hash_byte_in       = '0;
        hash_byte_pulse_in = 1'b0;
        clear_err          = 1'b0;
        exp_count          = '0;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst.valid", 32'(data_out_valid), 32'd0);
        chk("rst.data", 32'(data_out), 32'd0);
        chk("rst.req", 32'(request_hash_byte_pulse), 32'd0);
        chk("rst.count", byte_count_out, 32'd0);
        chk("rst.err", 32'(timeout_err_out), 32'd0);
        chk("rst.ready", 32'(data_in_ready), 32'd1);
        nrst = 1'b1;
        @(negedge clk);
        chk("rst.no_req_first", 32'(request_hash_byte_pulse), 32'd0);

        // Directed vectors: delays stay below the timeout; ks_dly=3 puts the
        // pulse on the would-be timeout cycle.
        vecs[0] = '{d: 8'h41, k: 8'h5A, ks_dly: 1, sink_dly: 0,  junk: 1'b0, exp_out: 8'h1B};
        vecs[1] = '{d: 8'h00, k: 8'h00, ks_dly: 0, sink_dly: 0,  junk: 1'b0, exp_out: 8'h00};
        vecs[2] = '{d: 8'hFF, k: 8'h0F, ks_dly: 0, sink_dly: 1,  junk: 1'b1, exp_out: 8'hF0};
        vecs[3] = '{d: 8'hA5, k: 8'h5A, ks_dly: 2, sink_dly: 10, junk: 1'b0, exp_out: 8'hFF};
        vecs[4] = '{d: 8'h12, k: 8'h34, ks_dly: 3, sink_dly: 2,  junk: 1'b1, exp_out: 8'h26};
        vecs[5] = '{d: 8'h80, k: 8'h01, ks_dly: 0, sink_dly: 0,  junk: 1'b0, exp_out: 8'h81};
        for (int v = 0; v < 6; v++) begin
            xfer($sformatf("vec%0d", v), vecs[v].d, vecs[v].k, vecs[v].ks_dly,
                 vecs[v].sink_dly, vecs[v].junk, vecs[v].exp_out);
        end
        chk("vec.no_timeout", 32'(timeout_err_out), 32'd0);

        // Randomized transfers against the XOR/count reference model.
        for (int r = 0; r < 24; r++) begin
            rd = 8'($urandom);
            rk = 8'($urandom);
            xfer($sformatf("rnd%0d", r), rd, rk, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rd ^ rk);
        end

        // Timeout: flag rises after Timeout idle WAIT_KS cycles; clear loses
        // to a same-cycle timeout; the late byte is still delivered.
        req0          = req_cnt;
        data_in       = 8'h0F;
        data_in_valid = 1'b1;
        @(negedge clk);
        data_in_valid = 1'b0;
        chk("to.req", 32'(request_hash_byte_pulse), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("to.err_low%0d", i), 32'(timeout_err_out), 32'd0);
            if (i == 4) clear_err = 1'b1;
        end
        @(negedge clk);
        clear_err = 1'b0;
        chk("to.err_wins", 32'(timeout_err_out), 32'd1);
        repeat (5) @(negedge clk);
        chk("to.err_sticky", 32'(timeout_err_out), 32'd1);
        chk("to.no_out", 32'(data_out_valid), 32'd0);
        chk("to.one_req", 32'(req_cnt - req0), 32'd1);
        hash_byte_in       = 8'hFF;
        hash_byte_pulse_in = 1'b1;
        @(negedge clk);
        hash_byte_pulse_in = 1'b0;
        chk("to.late_valid", 32'(data_out_valid), 32'd1);
        chk("to.late_data", 32'(data_out), 32'hF0);
        data_out_ready = 1'b1;
        @(negedge clk);
        data_out_ready = 1'b0;
        exp_count      = exp_count + 32'd1;
        chk("to.count", byte_count_out, exp_count);
        chk("to.err_kept", 32'(timeout_err_out), 32'd1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        chk("to.cleared", 32'(timeout_err_out), 32'd0);

        // Reset while waiting for keystream (flag already set by then).
        data_in       = 8'h99;
        data_in_valid = 1'b1;
        @(negedge clk);
        data_in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("rw.err_before", 32'(timeout_err_out), 32'd1);
        nrst = 1'b0;
        #1;
        chk("rw.valid", 32'(data_out_valid), 32'd0);
        chk("rw.data", 32'(data_out), 32'd0);
        chk("rw.req", 32'(request_hash_byte_pulse), 32'd0);
        chk("rw.count", byte_count_out, 32'd0);
        chk("rw.err", 32'(timeout_err_out), 32'd0);
        chk("rw.ready", 32'(data_in_ready), 32'd1);
        @(negedge clk);
        nrst      = 1'b1;
        exp_count = '0;
        // Stray keystream pulse while idle must be ignored.
        hash_byte_in       = 8'h77;
        hash_byte_pulse_in = 1'b1;
        @(negedge clk);
        hash_byte_pulse_in = 1'b0;
        chk("rw.no_req_first", 32'(request_hash_byte_pulse), 32'd0);
        chk("rw.idle_pulse", 32'(data_out_valid), 32'd0);
        xfer("post_rst", 8'h41, 8'h5A, 1, 0, 1'b0, 8'h1B);

        // Counter wrap from all-ones.
        force dut.r_byte_count = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.r_byte_count;
        exp_count = 32'hFFFF_FFFE;
        chk("wrap.preload", byte_count_out, exp_count);
        xfer("wrap_a", 8'h3C, 8'hC3, 0, 0, 1'b0, 8'hFF);
        xfer("wrap_b", 8'h01, 8'h02, 1, 1, 1'b0, 8'h03);
        chk("wrap.zero", byte_count_out, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/keystream_xor.md
KEYSTREAM_XOR -- requirements
Module: keystream_xor

Interface
REQ-001 SHALL have parameter WAIT_TIMEOUT, default 255, giving the maximum cycles to wait for a keystream byte before flagging an error (range 1..65535).
REQ-002 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-003 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port data_in  input  8  plaintext/ciphertext byte.
REQ-005 SHALL have port data_in_valid  input  1  data_in valid.
REQ-006 SHALL have port data_in_ready  output  1  block can accept data_in.
REQ-007 SHALL have port data_out  output  8  data_in XOR keystream byte.
REQ-008 SHALL have port data_out_valid  output  1  data_out valid.
REQ-009 SHALL have port data_out_ready  input  1  sink accepts data_out.
REQ-010 SHALL have port request_hash_byte_pulse  output  1  one-cycle keystream byte request to hash_generator.
REQ-011 SHALL have port hash_byte_in  input  8  keystream byte from hash_generator.
REQ-012 SHALL have port hash_byte_pulse_in  input  1  hash_byte_in valid for this cycle only.
REQ-013 SHALL have port byte_count_out  output  32  count of bytes delivered on data_out.
REQ-014 SHALL have port timeout_err_out  output  1  sticky keystream-timeout flag.
REQ-015 SHALL have port clear_err  input  1  synchronous clear of timeout_err_out.

Function
REQ-016 SHALL implement states IDLE, REQ, WAIT_KS, OUT.
REQ-017 IDLE: data_in_ready=1; on data_in_valid&data_in_ready, SHALL latch data_in, go REQ; data_in_ready=0 in all other states.
REQ-018 REQ: SHALL assert request_hash_byte_pulse for exactly one cycle, go WAIT_KS, clear wait timer.
REQ-019 WAIT_KS: on hash_byte_pulse_in, SHALL register data_out = latched byte XOR hash_byte_in, go OUT.
REQ-020 WAIT_KS: wait timer SHALL increment each cycle without pulse; on reaching WAIT_TIMEOUT, SHALL set timeout_err_out and remain in WAIT_KS (byte never dropped, timer saturates).
REQ-021 OUT: data_out_valid=1, data_out stable; on data_out_ready, SHALL increment byte_count_out (modulo 2^32, FFFFFFFF->0) and go IDLE.
REQ-022 hash_byte_pulse_in outside WAIT_KS SHALL be ignored (non-prefetch build).
REQ-023 Minimum latency (non-prefetch): accept edge N, request in cycle N+1, pulse earliest N+2, data_out_valid from N+3.
REQ-024 clear_err SHALL clear timeout_err_out; a timeout in the same cycle SHALL win (flag stays 1).
REQ-025 hash_byte_pulse_in and timeout in the same WAIT_KS cycle: byte SHALL be used and timeout_err_out SHALL NOT be set.

Reset
REQ-026 nrst low SHALL immediately force IDLE, data_out=0, data_out_valid=0, request_hash_byte_pulse=0, byte_count_out=0, timeout_err_out=0, timer=0, discarding any byte in flight.
REQ-027 No request pulse SHALL be issued in the first cycle after nrst deasserts.

Configuration
REQ-028 Macro KEYSTREAM_XOR_PREFETCH_EN defined: block SHALL hold one keystream byte buffer (ks_buf, ks_valid) and, whenever ks_valid=0 and no request is outstanding, issue a request in any state and capture the next pulse.
REQ-029 With prefetch: IDLE accept with ks_valid=1 SHALL go directly to OUT with data_out = data_in XOR ks_buf (one-cycle latency), consuming ks_buf; with ks_valid=0 SHALL go WAIT_KS (no extra request); REQ state unused.
REQ-030 Macro undefined: no buffer, behaviour exactly REQ-016..REQ-025.

Structure
REQ-031 Package stream_cipher_pkg SHALL hold keystream_xor_state_t enum and localparam ByteWidth=8.
REQ-032 Wait timer SHALL be sub-module keystream_timeout_counter (clear, enable, saturate-at-limit, expired flag).

Verification
REQ-033 data_in=0x41, keystream 0x5A after 1-cycle delay, sink ready -> one request pulse, data_out=0x1B, byte_count_out=1.
REQ-034 Sink holds data_out_ready=0 for 10 cycles -> data_out_valid and data_out stable, data_in_ready=0, no extra request.
REQ-035 No hash pulse, WAIT_TIMEOUT=4 -> timeout_err_out=1 after 4 WAIT_KS cycles; late pulse 0xFF with data 0x0F -> data_out=0xF0; clear_err -> flag 0.
REQ-036 nrst asserted in WAIT_KS -> all outputs reset immediately; subsequent byte processed normally with count 1.
REQ-037 byte_count_out preloaded via 2^32-1 transfers (force) -> next transfer wraps to 0.
REQ-038 PREFETCH_EN: after reset one request issued unprompted; keystream 0xAA buffered; data_in=0x55 -> data_out=0xFF next cycle, new request follows.
